pmips_mem_arbiter: RTL and testbench

//  Shares one single-ported 17-bit-wide memory between the PMIPS fetch port (17-bit instructions) and
//  the data port (16-bit loads/stores). Sits between the pipeline's imem/dmem ports and the memory

---
 rtl/pmips_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_pmips_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmips_mem_arbiter.sv
// PMIPS fetch/data arbiter for one shared 17-bit single-ported memory.
// Optional one-entry fetch buffer: define PMIPS_ARB_FETCH_BUF_EN.
module pmips_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [16:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [16:0] mem_wdata,
  input  logic [16:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } state_e;

  state_e        state_q;
  logic [SW-1:0] starve_q;
  logic [TW-1:0] tmo_q;

  logic          mem_req_q;
  logic          mem_we_q;
  logic [15:0]   mem_addr_q;
  logic [16:0]   mem_wdata_q;
  logic [16:0]   if_rdata_q;
  logic [15:0]   dm_rdata_q;
  logic          if_ready_q;
  logic          dm_ready_q;
  logic          err_q;

  logic          dm_req;
  logic          dm_win;
  logic          starve_lim;
  logic          tmo_hit;
  logic          buf_hit;

  assign dm_req     = dm_read | dm_write;
  assign starve_lim = (starve_q >= SW'(STARVE_MAX));
  assign dm_win     = dm_req & (~starve_lim | ~if_req);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));

`ifdef PMIPS_ARB_FETCH_BUF_EN
  logic          buf_vld_q;
  logic [15:0]   buf_addr_q;
  logic [16:0]   buf_data_q;

  assign buf_hit = buf_vld_q & (buf_addr_q == if_addr);

  // Filled by every completed fetch; a store to the same word invalidates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      if (state_q == BUSY_IF && mem_ack) begin
        buf_vld_q  <= 1'b1;
        buf_addr_q <= mem_addr_q;
        buf_data_q <= mem_rdata;
      end else if (state_q == IDLE && dm_win && dm_write
                   && dm_addr == buf_addr_q) begin
        buf_vld_q  <= 1'b0;
      end
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (dm_read && dm_write) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (dm_win) begin
            state_q     <= BUSY_DM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_write;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= {1'b0, dm_wdata};
            tmo_q       <= '0;
            if (if_req && !starve_lim) begin
              starve_q <= starve_q + SW'(1);
            end
          end else if (if_req) begin
            starve_q <= '0;
`ifdef PMIPS_ARB_FETCH_BUF_EN
            if (buf_hit) begin
              state_q    <= RESP;
              if_ready_q <= 1'b1;
              if_rdata_q <= buf_data_q;
            end else begin
`else
            begin
`endif
              state_q     <= BUSY_IF;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              tmo_q       <= '0;
            end
          end
        end
        BUSY_IF, BUSY_DM: begin
          // An ack on the last allowed cycle still completes normally.
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == BUSY_IF) begin
              if_rdata_q <= mem_rdata;
              if_ready_q <= 1'b1;
            end else begin
              dm_rdata_q <= mem_rdata[15:0];
              dm_ready_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= 1'b1;
            if (state_q == BUSY_IF) begin
              if_rdata_q <= '1;
              if_ready_q <= 1'b1;
            end else begin
              dm_rdata_q <= '1;
              dm_ready_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        RESP: begin
          state_q    <= IDLE;
          if_ready_q <= 1'b0;
          dm_ready_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// Directed bench for pmips_mem_arbiter with a small memory responder.
// Buffer checks run when PMIPS_ARB_FETCH_BUF_EN is defined.
module tb_pmips_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic [16:0] if_rdata;
  logic        if_ready;
  logic        dm_read;
  logic        dm_write;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [16:0] mem_wdata;
  logic [16:0] mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [16:0] mem_model [256];
  int          ack_dly = 1;
  int          req_cnt = 0;

  always #5 clock = ~clock;

  pmips_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall    (stall),
    .err      (err)
  );

  // Acks on the ack_dly-th cycle of mem_req; ack_dly=0 never acks.
  always @(posedge clock) begin
    #1;
    if (mem_req) begin
      req_cnt++;
      if (ack_dly != 0 && req_cnt == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model[mem_addr[7:0]];
        if (mem_we) mem_model[mem_addr[7:0]] = mem_wdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
      end
    end else begin
      req_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"},   32'(mem_req),   32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, " if_rdata"},  32'(if_rdata),  32'h0);
    check({tag, " dm_rdata"},  32'(dm_rdata),  32'h0);
    check({tag, " if_ready"},  32'(if_ready),  32'h0);
    check({tag, " dm_ready"},  32'(dm_ready),  32'h0);
    check({tag, " err"},       32'(err),       32'h0);
  endtask

  logic [9:0] grant_exp;
  int         g;

  initial begin
    reset    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h10] = 17'h1ABCD;
    mem_model[8'h11] = 17'h00777;
    mem_model[8'h20] = 17'h12345;

    repeat (2) smp();
    check_all_zero("rst");
    check("rst stall", 32'(stall), 32'h0);
    reset = 1'b1;
    step();

    // fetch 0x0010
    step();
    if_req = 1'b1; if_addr = 16'h0010;
    smp();
    check("f c0 stall", 32'(stall), 32'h1);
    check("f c0 mem_req", 32'(mem_req), 32'h0);
    step(); smp();
    check("f c1 mem_req", 32'(mem_req), 32'h1);
    check("f c1 mem_addr", 32'(mem_addr), 32'h0010);
    check("f c1 mem_we", 32'(mem_we), 32'h0);
    check("f c1 stall", 32'(stall), 32'h1);
    step(); smp();
    check("f c2 if_ready", 32'(if_ready), 32'h1);
    check("f c2 if_rdata", 32'(if_rdata), 32'h1ABCD);
    check("f c2 stall", 32'(stall), 32'h0);
    check("f c2 mem_req", 32'(mem_req), 32'h0);
    step();
    if_req = 1'b0;
    smp();
    check("f c3 if_ready", 32'(if_ready), 32'h0);

    // store 0xBEEF to 0x0042
    step();
    dm_write = 1'b1; dm_addr = 16'h0042; dm_wdata = 16'hBEEF;
    step(); smp();
    check("st mem_req", 32'(mem_req), 32'h1);
    check("st mem_we", 32'(mem_we), 32'h1);
    check("st mem_addr", 32'(mem_addr), 32'h0042);
    check("st mem_wdata", 32'(mem_wdata), 32'h0BEEF);
    step(); smp();
    check("st dm_ready", 32'(dm_ready), 32'h1);
    step();
    dm_write = 1'b0;

    // load back 0x0042
    step();
    dm_read = 1'b1;
    step(); smp();
    check("ld mem_we", 32'(mem_we), 32'h0);
    step(); smp();
    check("ld dm_ready", 32'(dm_ready), 32'h1);
    check("ld dm_rdata", 32'(dm_rdata), 32'hBEEF);
    step();
    dm_read = 1'b0;

    // contention: 1 = fetch grant, 0 = data grant (index 0 first)
    grant_exp = 10'b10000_10000;
    step();
    dm_read = 1'b1; dm_addr = 16'h0042;
    if_req  = 1'b1; if_addr = 16'h0010;
    g = 0;
    for (int c = 0; c < 60 && g < 10; c++) begin
      smp();
      if (if_ready || dm_ready) begin
        check($sformatf("grant%0d", g), 32'(if_ready), 32'(grant_exp[g]));
        g++;
      end
      step();
    end
    check("grant count", 32'(g), 32'd10);
    dm_read = 1'b0;
    if_req  = 1'b0;

    // ack on the 16th busy cycle: ack wins, no err
    step();
    ack_dly = 16; dm_read = 1'b1; dm_addr = 16'h0042;
    repeat (16) step();
    smp();
    check("lim c16 mem_req", 32'(mem_req), 32'h1);
    step(); smp();
    check("lim dm_ready", 32'(dm_ready), 32'h1);
    check("lim dm_rdata", 32'(dm_rdata), 32'hBEEF);
    check("lim err", 32'(err), 32'h0);
    step();
    dm_read = 1'b0;

    // timeout: never ack
    step();
    ack_dly = 0; dm_read = 1'b1; dm_addr = 16'h0055;
    repeat (16) step();
    smp();
    check("to c16 mem_req", 32'(mem_req), 32'h1);
    check("to c16 err", 32'(err), 32'h0);
    step(); smp();
    check("to mem_req", 32'(mem_req), 32'h0);
    check("to dm_ready", 32'(dm_ready), 32'h1);
    check("to dm_rdata", 32'(dm_rdata), 32'hFFFF);
    check("to err", 32'(err), 32'h1);
    step();
    dm_read = 1'b0; ack_dly = 1;

    // err stays set across a normal fetch
    step();
    if_req = 1'b1; if_addr = 16'h0011;
    step(); step(); smp();
    check("sticky if_ready", 32'(if_ready), 32'h1);
    check("sticky if_rdata", 32'(if_rdata), 32'h00777);
    check("sticky err", 32'(err), 32'h1);
    step();
    if_req = 1'b0;

    // async reset in the middle of a data access
    step();
    ack_dly = 0; dm_read = 1'b1; dm_addr = 16'h0030;
    step(); step(); smp();
    check("mid mem_req", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst mem_req", 32'(mem_req), 32'h0);
    check("arst err", 32'(err), 32'h0);
    dm_read = 1'b0; ack_dly = 1;
    smp();
    reset = 1'b1;
    #1;
    check_all_zero("rel");
    step();

    // read and write together: write wins, err set
    step();
    dm_read = 1'b1; dm_write = 1'b1;
    dm_addr = 16'h0060; dm_wdata = 16'h1234;
    smp();
    check("rw c0 err", 32'(err), 32'h0);
    step(); smp();
    check("rw mem_we", 32'(mem_we), 32'h1);
    check("rw mem_wdata", 32'(mem_wdata), 32'h01234);
    check("rw err", 32'(err), 32'h1);
    step(); smp();
    check("rw dm_ready", 32'(dm_ready), 32'h1);
    step();
    dm_read = 1'b0; dm_write = 1'b0;

`ifdef PMIPS_ARB_FETCH_BUF_EN
    // first fetch of 0x0020 misses
    step();
    if_req = 1'b1; if_addr = 16'h0020;
    step(); smp();
    check("b1 mem_req", 32'(mem_req), 32'h1);
    step(); smp();
    check("b1 if_ready", 32'(if_ready), 32'h1);
    check("b1 if_rdata", 32'(if_rdata), 32'h12345);
    step();
    if_req = 1'b0;

    // second fetch hits: ready in cycle 1, no memory request
    step();
    if_req = 1'b1;
    step(); smp();
    check("b2 mem_req", 32'(mem_req), 32'h0);
    check("b2 if_ready", 32'(if_ready), 32'h1);
    check("b2 if_rdata", 32'(if_rdata), 32'h12345);
    step();
    if_req = 1'b0;

    // store to 0x0020 invalidates
    step();
    dm_write = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h5555;
    step(); step(); smp();
    check("b st dm_ready", 32'(dm_ready), 32'h1);
    step();
    dm_write = 1'b0;

    step();
    if_req = 1'b1;
    step(); smp();
    check("b3 mem_req", 32'(mem_req), 32'h1);
    check("b3 if_ready", 32'(if_ready), 32'h0);
    step(); smp();
    check("b3 if_rdata", 32'(if_rdata), 32'h05555);
    step();
    if_req = 1'b0;
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
